// File: rtl/pipe_elastic_reg.sv
// Multi-stage elastic pipeline register: per-stage main+skid storage with
// registered valid/ready, synchronous flush and an occupancy count.
module pipe_elastic_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int unsigned     CW        = $clog2(2*STAGES+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  // Encoding puts ready in bit 1 and valid in bit 0, so both handshake
  // outputs of every stage come straight off a flop.
  localparam logic [1:0] ST_EMPTY = 2'b10;
  localparam logic [1:0] ST_ONE   = 2'b11;
  localparam logic [1:0] ST_TWO   = 2'b01;

  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_ready;
  logic [STAGES-1:0] w_full;
  logic [WIDTH-1:0]  w_main [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_up_valid;
    logic [WIDTH-1:0] w_up_data;
    logic             w_dn_ready;
    logic             w_push;
    logic             w_pop;

    if (k == 0) begin : g_head
      assign w_up_valid = in_valid;
      assign w_up_data  = in_data;
    end else begin : g_link
      assign w_up_valid = w_valid[k-1];
      assign w_up_data  = w_main[k-1];
    end

    if (k == STAGES - 1) begin : g_tail
      assign w_dn_ready = out_ready;
    end else begin : g_next
      assign w_dn_ready = w_ready[k+1];
    end

    assign w_valid[k] = r_state[0];
    assign w_ready[k] = r_state[1];
    assign w_full[k]  = ~r_state[1];
    assign w_main[k]  = r_main;
    assign w_push     = w_up_valid & r_state[1];
    assign w_pop      = r_state[0] & w_dn_ready;

    // Next-state and data steering for this stage
    always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = w_up_data;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_main_nxt  = w_up_data;
          end else if (w_push) begin
            w_state_nxt = ST_TWO;
            w_skid_nxt  = w_up_data;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
      // Squash drops occupancy only; stored data is left untouched
      if (flush) begin
        w_state_nxt = ST_EMPTY;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= ST_EMPTY;
        r_main  <= RESET_VAL;
        r_skid  <= RESET_VAL;
      end else begin
        r_state <= w_state_nxt;
        r_main  <= w_main_nxt;
        r_skid  <= w_skid_nxt;
      end
    end
  end

  logic          w_fire_in;
  logic          w_fire_out;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_occ;

  assign w_fire_in  = in_valid & w_ready[0] & ~flush;
  assign w_fire_out = w_valid[STAGES-1] & out_ready & ~flush;

  // Occupancy tracks accepted minus delivered words
  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else if (w_fire_in && !w_fire_out) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_fire_in && w_fire_out) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[STAGES-1];
  assign out_data  = w_main[STAGES-1];
  assign count     = r_count;

  // The running count must always equal the words physically held
  assign w_occ = CW'($countones(w_valid)) + CW'($countones(w_full));

  a_count_matches_occupancy : assert property (
    @(posedge clk) disable iff (reset) r_count == w_occ
  );

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Randomized and directed bench for pipe_elastic_reg with a FIFO-queue
// reference model of accepted-but-undelivered words.
module tb_pipe_elastic_reg;

  localparam int unsigned  WIDTH  = 8;
  localparam int unsigned  STAGES = 3;
  localparam logic [7:0]   RV     = 8'hA5;
  localparam int unsigned  CW     = $clog2(2*STAGES+1);

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  pipe_elastic_reg #(
    .WIDTH    (WIDTH),
    .STAGES   (STAGES),
    .RESET_VAL(RV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  logic [7:0]    q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            n_acc    = 0;
  int            n_del    = 0;
  logic          s_in_ready;
  logic          s_out_valid;
  logic [7:0]    s_out_data;
  logic [CW-1:0] s_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive, sample mid-cycle, check against the queue, update it.
  task automatic step(input logic rst, input logic f, input logic v,
                      input logic [7:0] d, input logic r);
    reset = rst; flush = f; in_valid = v; in_data = d; out_ready = r;
    @(negedge clk);
    cyc++;
    s_in_ready = in_ready; s_out_valid = out_valid;
    s_out_data = out_data; s_count = count;
    check("count", 32'(count), 32'(q.size()));
    if (q.size() == 0) check("ovalid_idle", 32'(out_valid), 32'(0));
    else if (out_valid) check("odata", 32'(out_data), 32'(q[0]));
    if (rst || f) begin
      q.delete();
    end else begin
      if (out_valid && r) begin
        if (q.size() > 0) void'(q.pop_front());
        n_del++;
      end
      if (v && in_ready) begin
        q.push_back(d);
        n_acc++;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int t_in;
    int t_out;
    int a0;
    int d0;
    int lat;
    logic [7:0] first;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ovalid", 32'(out_valid), 32'(0));
    check("rst_odata",  32'(out_data),  32'(RV));
    check("rst_count",  32'(count),     32'(0));
    check("rst_iready", 32'(in_ready),  32'(1));
    @(posedge clk); #1;

    // Streaming at full rate
    t_in = -1; t_out = -1;
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
      if (t_in < 0 && s_in_ready) t_in = cyc;
      if (t_out < 0 && s_out_valid) begin
        t_out = cyc;
        check("stream_first", 32'(s_out_data), 32'h01);
      end
      if (t_out >= 0) begin
        check("stream_ovalid", 32'(s_out_valid), 32'(1));
        check("stream_count",  32'(s_count),     32'(STAGES));
      end
    end
    check("stream_latency", 32'(t_out - t_in), 32'(STAGES));
    repeat (8) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("stream_delivered", 32'(n_del), 32'(16));
    check("stream_idle", 32'(s_out_valid), 32'(0));

    // Fill to capacity under backpressure, then release
    a0 = n_acc; d0 = n_del;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    check("full_accepted", 32'(n_acc - a0), 32'(2*STAGES));
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("full_iready", 32'(s_in_ready), 32'(0));
    check("full_count",  32'(s_count),    32'(2*STAGES));
    repeat (10) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("full_delivered", 32'(n_del - d0), 32'(2*STAGES));

    // Full with both sides active: ready recovers and streaming resumes
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    lat = -1;
    for (int i = 1; i <= 2*STAGES + 2; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'(8'h50 + i), 1'b1);
      if (lat < 0 && s_in_ready) lat = i;
    end
    check("refill_ready_back", 32'(lat > 0 && lat <= int'(2*STAGES)), 32'(1));
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'(8'h60 + i), 1'b1);
      check("refill_stream", 32'(s_out_valid), 32'(1));
    end
    repeat (12) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Flush with 4 words held and a word offered in the same cycle
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    d0 = n_del;
    step(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
    check("flush_pre_count", 32'(s_count), 32'(4));
    step(1'b0, 1'b0, 1'b1, 8'h66, 1'b1);
    check("flush_count",  32'(s_count),     32'(0));
    check("flush_ovalid", 32'(s_out_valid), 32'(0));
    check("flush_accept", 32'(s_in_ready),  32'(1));
    lat = -1; first = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      if (lat < 0 && s_out_valid) begin
        lat = i;
        first = s_out_data;
      end
    end
    check("flush_latency", 32'(lat), 32'(STAGES));
    check("flush_next",    32'(first), 32'h66);
    check("flush_only_one", 32'(n_del - d0), 32'(1));

    // Reset while full with flush also asserted
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("rst2_ovalid", 32'(s_out_valid), 32'(0));
    check("rst2_odata",  32'(s_out_data),  32'(RV));
    check("rst2_count",  32'(s_count),     32'(0));
    check("rst2_iready", 32'(s_in_ready),  32'(1));

    // Random traffic
    a0 = n_acc; d0 = n_del;
    for (int i = 0; i < 10000; i++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (20) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("rand_balance", 32'(n_acc - a0), 32'(n_del - d0));
    check("rand_idle", 32'(s_out_valid), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
